// File: rtl/unidade_logica_mc.sv
// unidade_logica_mc: multi-cycle bitwise logic unit (AND/OR/XOR/NOR).
// Processes LANE bits of the latched operands per clock and presents the
// full result, the zero flag and a one-cycle done pulse under the usual
// start/busy/done handshake of the multicycle datapath.
module unidade_logica_mc #(
  parameter int WIDTH = 32,
  parameter int LANE  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] entrada_1,
  input  logic [WIDTH-1:0] entrada_2,
  output logic [WIDTH-1:0] saida,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / LANE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [1:0]       opSel_q;
  logic [WIDTH-1:0] opA_q;
  logic [WIDTH-1:0] opB_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] saida_q;
  logic             zero_q;
  logic             busy_q;
  logic             done_q;
  logic [CW-1:0]    cnt_q;

  logic [LANE-1:0]  laneA;
  logic [LANE-1:0]  laneB;
  logic [LANE-1:0]  lane_d;
  logic [WIDTH-1:0] result_d;

  // Current lane of both operands, its logic result, and the full result
  // formed by merging that lane into the accumulator.
  always_comb begin
    laneA    = opA_q[int'(cnt_q)*LANE +: LANE];
    laneB    = opB_q[int'(cnt_q)*LANE +: LANE];
    lane_d   = '0;
    case (opSel_q)
      2'b00:   lane_d = laneA & laneB;
      2'b01:   lane_d = laneA | laneB;
      2'b10:   lane_d = laneA ^ laneB;
      default: lane_d = ~(laneA | laneB);
    endcase
    result_d = acc_q;
    result_d[int'(cnt_q)*LANE +: LANE] = lane_d;
  end

  // Control FSM with registered outputs; reset discards any running operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      opSel_q <= 2'b00;
      opA_q   <= '0;
      opB_q   <= '0;
      acc_q   <= '0;
      saida_q <= '0;
      zero_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            opSel_q <= op;
            opA_q   <= entrada_1;
            opB_q   <= entrada_2;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q[int'(cnt_q)*LANE +: LANE] <= lane_d;
          if (cnt_q == LAST) begin
            saida_q <= result_d;
            zero_q  <= (result_d == '0);
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign saida = saida_q;
  assign zero  = zero_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
